// File: rtl/stack_rpn_sequencer.sv
// stack_rpn_sequencer
//   Evaluates reverse-Polish token streams on an external operand stack.
//   Each accepted token becomes at most one stack opcode; the sequencer
//   tracks stack depth itself so it can reject underflow, depth overflow and
//   malformed END tokens. After an error it pops the stack empty, discards
//   the rest of the expression through its END token when needed, and
//   reports one result per expression.
//
// Ports
//   clk, rst_n                    clock / async active-low reset
//   tok_valid/ready/kind/data     token stream (00 operand, 01 ADD, 10 MUL, 11 END)
//   stk_opcode, stk_data          commands to the stack (NOP/PUSH/POP/ADD/MUL)
//   stk_output_data, stk_overflow stack response, valid the cycle after issue
//   res_valid/ready/data/err      result stream (err 00 ok, 01 underflow,
//                                 10 depth overflow, 11 malformed END)
//   res_arith_ovf                 any ADD/MUL of the expression overflowed
//   depth_o                       current tracked stack depth
module stack_rpn_sequencer #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tok_valid,
  output logic                         tok_ready,
  input  logic [1:0]                   tok_kind,
  input  logic [WIDTH-1:0]             tok_data,
  output logic [2:0]                   stk_opcode,
  output logic [WIDTH-1:0]             stk_data,
  input  logic [WIDTH-1:0]             stk_output_data,
  input  logic                         stk_overflow,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [WIDTH-1:0]             res_data,
  output logic [1:0]                   res_err,
  output logic                         res_arith_ovf,
  output logic [$clog2(DEPTH+1)-1:0]   depth_o
);
  localparam int DW = $clog2(DEPTH+1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] ONE       = DW'(1);
  localparam logic [DW-1:0] TWO       = DW'(2);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_SKIP   = 3'd5;
  localparam logic [2:0] S_RESULT = 3'd6;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;

  localparam logic [1:0] K_OPND = 2'b00;
  localparam logic [1:0] K_ADD  = 2'b01;
  localparam logic [1:0] K_MUL  = 2'b10;
  localparam logic [1:0] K_END  = 2'b11;

  localparam logic [1:0] E_OK    = 2'b00;
  localparam logic [1:0] E_UNDER = 2'b01;
  localparam logic [1:0] E_DEPTH = 2'b10;
  localparam logic [1:0] E_END   = 2'b11;

  logic [2:0]       state;
  logic [2:0]       op_q;     // opcode presented during ISSUE
  logic [WIDTH-1:0] data_q;
  logic [DW-1:0]    depth;
  logic [1:0]       err;
  logic             sticky;
  logic [WIDTH-1:0] res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_INIT;
      op_q   <= OP_NOP;
      data_q <= '0;
      depth  <= '0;
      err    <= E_OK;
      sticky <= 1'b0;
      res_q  <= '0;
    end else begin
      case (state)
        S_INIT: state <= S_ACCEPT;
        S_ACCEPT: if (tok_valid) begin
          case (tok_kind)
            K_OPND: if (depth < DEPTH_MAX) begin
              op_q   <= OP_PUSH;
              data_q <= tok_data;
              depth  <= depth + ONE;
              state  <= S_ISSUE;
            end else begin
              err   <= E_DEPTH;
              state <= S_DRAIN;
            end
            K_ADD, K_MUL: if (depth >= TWO) begin
              op_q  <= (tok_kind == K_ADD) ? OP_ADD : OP_MUL;
              depth <= depth - ONE;  // pops two, pushes one
              state <= S_ISSUE;
            end else begin
              err   <= E_UNDER;
              state <= S_DRAIN;
            end
            default: if (depth == ONE) begin  // K_END
              op_q  <= OP_POP;
              depth <= '0;
              state <= S_ISSUE;
            end else begin
              err   <= E_END;
              state <= S_DRAIN;
            end
          endcase
        end
        // A PUSH needs no response; everything else waits for the stack.
        S_ISSUE: state <= (op_q == OP_PUSH) ? S_ACCEPT : S_WAIT;
        S_WAIT: if (op_q == OP_POP) begin
          res_q <= stk_output_data;
          state <= S_RESULT;
        end else begin
          sticky <= sticky | stk_overflow;
          state  <= S_ACCEPT;
        end
        // A malformed END was itself the last token, so nothing to skip.
        S_DRAIN: if (depth != '0) depth <= depth - ONE;
                 else state <= (err == E_END) ? S_RESULT : S_SKIP;
        S_SKIP: if (tok_valid && tok_kind == K_END) state <= S_RESULT;
        S_RESULT: if (res_ready) begin
          err    <= E_OK;
          sticky <= 1'b0;
          res_q  <= '0;
          state  <= S_ACCEPT;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    stk_opcode = OP_NOP;
    if (state == S_ISSUE)                      stk_opcode = op_q;
    else if (state == S_DRAIN && depth != '0) stk_opcode = OP_POP;
  end

  assign tok_ready     = (state == S_ACCEPT) || (state == S_SKIP);
  assign stk_data      = data_q;
  assign res_valid     = (state == S_RESULT);
  assign res_data      = (err == E_OK) ? res_q : '0;
  assign res_err       = err;
  assign res_arith_ovf = sticky;
  assign depth_o       = depth;
endmodule

// File: tb/tb_stack_rpn_sequencer.sv
// Bench for stack_rpn_sequencer: behavioural stack plus an expression-level
// model (queue of values) predicting the opcode stream and every result.
module tb_stack_rpn_sequencer;
  localparam int W  = 8;
  localparam int D  = 256;
  localparam int DW = $clog2(D+1);
  localparam logic [1:0] K_OP = 2'b00, K_ADD = 2'b01, K_MUL = 2'b10, K_END = 2'b11;
  localparam logic [2:0] C_NOP = 3'b000, C_PUSH = 3'b110, C_POP = 3'b111,
                         C_ADD = 3'b100, C_MUL = 3'b101;

  logic clk = 1'b0, rst_n = 1'b0;
  logic tok_valid = 1'b0, tok_ready;
  logic [1:0] tok_kind = 2'b00;
  logic [W-1:0] tok_data = '0;
  logic [2:0] stk_opcode;
  logic [W-1:0] stk_data, s_out;
  logic s_ovf;
  logic res_valid, res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic [1:0] res_err;
  logic res_arith_ovf;
  logic [DW-1:0] depth_o;

  always #5 clk = ~clk;

  stack_rpn_sequencer #(.DEPTH(D), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_kind(tok_kind), .tok_data(tok_data), .stk_opcode(stk_opcode),
    .stk_data(stk_data), .stk_output_data(s_out), .stk_overflow(s_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .res_arith_ovf(res_arith_ovf), .depth_o(depth_o));

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Two's-complement arithmetic of the stack: wrapped value and overflow.
  function automatic logic [W-1:0] ar_val(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, r;
    sa = int'($signed(a)); sb = int'($signed(b));
    r = (op == C_ADD) ? sa + sb : sa * sb;
    return W'(r);
  endfunction
  function automatic logic ar_ovf(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, r;
    sa = int'($signed(a)); sb = int'($signed(b));
    r = (op == C_ADD) ? sa + sb : sa * sb;
    return (r > (2**(W-1)) - 1) || (r < -(2**(W-1)));
  endfunction

  // Stack: samples at the edge, responds in the following cycle.
  logic [W-1:0] smem [D];
  int sp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= 0; s_out <= '0; s_ovf <= 1'b0;
    end else begin
      s_ovf <= 1'b0;
      case (stk_opcode)
        C_PUSH: if (sp < D) begin smem[sp] <= stk_data; sp <= sp + 1; end
        C_POP:  if (sp > 0) begin s_out <= smem[sp-1]; sp <= sp - 1; end
        C_ADD, C_MUL: if (sp >= 2) begin
          smem[sp-2] <= ar_val(stk_opcode, smem[sp-2], smem[sp-1]);
          s_out      <= ar_val(stk_opcode, smem[sp-2], smem[sp-1]);
          s_ovf      <= ar_ovf(stk_opcode, smem[sp-2], smem[sp-1]);
          sp         <= sp - 1;
        end
        default: ;
      endcase
    end
  end

  // Expression-level reference model.
  typedef struct { logic [2:0] op; logic [W-1:0] d; } op_t;
  typedef struct { logic [W-1:0] d; logic [1:0] e; logic o; } res_t;
  op_t  exp_ops[$];
  res_t exp_res[$];
  logic [W-1:0] mstk[$];
  logic mskip = 1'b0, movf = 1'b0;
  logic [1:0] merr = 2'b00;

  function automatic op_t mk_op(input logic [2:0] op, input logic [W-1:0] d);
    op_t t; t.op = op; t.d = d; return t;
  endfunction
  function automatic res_t mk_res(input logic [W-1:0] d, input logic [1:0] e, input logic o);
    res_t t; t.d = d; t.e = e; t.o = o; return t;
  endfunction

  task automatic m_fail(input logic [1:0] e);
    repeat (mstk.size()) exp_ops.push_back(mk_op(C_POP, '0));
    mstk.delete();
    if (e == 2'b11) begin exp_res.push_back(mk_res('0, e, movf)); movf = 1'b0; end
    else begin mskip = 1'b1; merr = e; end
  endtask

  task automatic model_token(input logic [1:0] k, input logic [W-1:0] d);
    logic [W-1:0] a, b;
    logic [2:0] op;
    if (mskip) begin
      if (k == K_END) begin
        exp_res.push_back(mk_res('0, merr, movf));
        mskip = 1'b0; merr = 2'b00; movf = 1'b0;
      end
      return;
    end
    case (k)
      K_OP: if (mstk.size() < D) begin
        mstk.push_back(d); exp_ops.push_back(mk_op(C_PUSH, d));
      end else m_fail(2'b10);
      K_ADD, K_MUL: if (mstk.size() >= 2) begin
        op = (k == K_ADD) ? C_ADD : C_MUL;
        b = mstk.pop_back(); a = mstk.pop_back();
        mstk.push_back(ar_val(op, a, b));
        movf = movf | ar_ovf(op, a, b);
        exp_ops.push_back(mk_op(op, '0));
      end else m_fail(2'b01);
      default: if (mstk.size() == 1) begin
        a = mstk.pop_back();
        exp_ops.push_back(mk_op(C_POP, '0));
        exp_res.push_back(mk_res(a, 2'b00, movf));
        movf = 1'b0;
      end else m_fail(2'b11);
    endcase
  endtask

  // Result consumer: 0 random, 1 hold low, 2 hold high.
  int rr_mode = 1;
  initial forever begin
    @(posedge clk); #1;
    case (rr_mode)
      0: res_ready = 1'($urandom_range(0, 1));
      1: res_ready = 1'b0;
      default: res_ready = 1'b1;
    endcase
  end

  // Compare process: opcode stream, results, per-cycle invariants.
  int cur_run = 0, last_run = 0, n_push = 0, n_pop = 0, n_ari = 0;
  logic prev_v = 1'b0, prev_hs = 1'b0, hs;
  logic [W-1:0] pd; logic [1:0] pe; logic po;
  op_t o; res_t r;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_v = 1'b0; cur_run = 0;
    end else begin
      if (tok_ready) chk("tok_ready_with_opcode", int'(stk_opcode), int'(C_NOP));
      if (res_valid) chk("result_quiet", int'({tok_ready, stk_opcode, depth_o}), 0);
      if (stk_opcode == C_POP) cur_run++;
      else if (cur_run > 0) begin last_run = cur_run; cur_run = 0; end
      if (stk_opcode != C_NOP) begin
        if (stk_opcode == C_PUSH) n_push++;
        else if (stk_opcode == C_POP) n_pop++;
        else n_ari++;
        if (exp_ops.size() == 0) chk("opcode_unexpected", int'(stk_opcode), int'(C_NOP));
        else begin
          o = exp_ops.pop_front();
          chk("opcode", int'(stk_opcode), int'(o.op));
          if (o.op == C_PUSH) chk("push_data", int'(stk_data), int'(o.d));
        end
      end
      if (res_valid && prev_v && !prev_hs)
        chk("result_stable", int'({res_data, res_err, res_arith_ovf}), int'({pd, pe, po}));
      hs = res_valid && res_ready;
      if (hs) begin
        if (exp_res.size() == 0) chk("result_unexpected", int'(res_valid), 0);
        else begin
          r = exp_res.pop_front();
          chk("res_data", int'(res_data), int'(r.d));
          chk("res_err", int'(res_err), int'(r.e));
          chk("res_arith_ovf", int'(res_arith_ovf), int'(r.o));
        end
      end
      prev_v = res_valid; prev_hs = hs;
      pd = res_data; pe = res_err; po = res_arith_ovf;
    end
  end

  // Offer one token; feeds the model on the accepting edge.
  task automatic send(input logic [1:0] k, input logic [W-1:0] d);
    int n;
    tok_valid = 1'b1; tok_kind = k; tok_data = d; n = 0;
    do begin @(negedge clk); n++; end while (!tok_ready && n < 1000);
    if (!tok_ready) begin
      chk("tok_accept_timeout", 0, 1);
    end else begin
      @(posedge clk);
      model_token(k, d);
    end
    #1 tok_valid = 1'b0;
  endtask

  task automatic wait_res(output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (!res_valid && k < 1000);
    if (!res_valid) chk("result_timeout", 0, 1);
  endtask

  task automatic release_res();
    int n;
    rr_mode = 2; n = 0;
    while (res_valid && n < 10) begin @(negedge clk); n++; end
    chk("result_released", int'(res_valid), 0);
    rr_mode = 1;
    @(posedge clk); #1;
  endtask

  task automatic clr_cnt();
    n_push = 0; n_pop = 0; n_ari = 0; last_run = 0;
  endtask

  initial begin
    int k;
    int t;
    logic [1:0] kk;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_opcode", int'(stk_opcode), 0);
    chk("rst_stk_data", int'(stk_data), 0);
    chk("rst_tok_ready", int'(tok_ready), 0);
    chk("rst_res", int'({res_valid, res_data, res_err, res_arith_ovf}), 0);
    chk("rst_depth", int'(depth_o), 0);
    rst_n = 1'b1;
    @(negedge clk) chk("init_tok_ready", int'(tok_ready), 0);
    @(negedge clk) chk("accept_tok_ready", int'(tok_ready), 1);
    @(posedge clk); #1;

    // 1 + (-2) = -1, latency END-accept to res_valid
    clr_cnt();
    send(K_OP, 8'h01); send(K_OP, 8'hFE); send(K_ADD, 8'h00); send(K_END, 8'h00);
    wait_res(k);
    chk("t1_latency", k, 3);
    chk("t1_data", int'(res_data), 8'hFF);
    chk("t1_err_ovf", int'({res_err, res_arith_ovf}), 0);
    chk("t1_ops", int'({8'(n_push), 8'(n_ari), 8'(n_pop)}), int'({8'd2, 8'd1, 8'd1}));
    release_res();

    // 0x7F + 1 overflows; sticky clears for the next expression
    send(K_OP, 8'h7F); send(K_OP, 8'h01); send(K_ADD, 8'h00); send(K_END, 8'h00);
    wait_res(k);
    chk("t2a_data", int'(res_data), 8'h80);
    chk("t2a_ovf", int'(res_arith_ovf), 1);
    chk("t2a_err", int'(res_err), 0);
    release_res();
    send(K_OP, 8'h02); send(K_OP, 8'h03); send(K_MUL, 8'h00); send(K_END, 8'h00);
    wait_res(k);
    chk("t2b_data", int'(res_data), 8'h06);
    chk("t2b_ovf", int'(res_arith_ovf), 0);
    release_res();

    // underflow: one POP drains, push 9 / END skipped
    clr_cnt();
    send(K_OP, 8'h05); send(K_ADD, 8'h00); send(K_OP, 8'h09); send(K_END, 8'h00);
    wait_res(k);
    chk("t3_err", int'(res_err), 1);
    chk("t3_data", int'(res_data), 0);
    chk("t3_ops", int'({8'(n_push), 8'(n_ari), 8'(n_pop)}), int'({8'd1, 8'd0, 8'd1}));
    release_res();

    // depth overflow: 256 pushes then one more operand
    clr_cnt();
    for (int i = 0; i < D; i++) send(K_OP, 8'($urandom));
    chk("t4_depth_full", int'(depth_o), D);
    send(K_OP, 8'h33);
    send(K_END, 8'h00);
    wait_res(k);
    chk("t4_pop_run", last_run, D);
    chk("t4_pops", n_pop, D);
    chk("t4_err", int'(res_err), 2);
    release_res();

    // malformed END: 2 POPs then straight to RESULT, held 5 cycles
    clr_cnt();
    send(K_OP, 8'h01); send(K_OP, 8'h02); send(K_END, 8'h00);
    wait_res(k);
    chk("t5_latency", k, 4);
    chk("t5_pops", n_pop, 2);
    chk("t5_err_data", int'({res_err, res_data}), int'({2'b11, 8'h00}));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold", int'({res_valid, res_err, res_data, tok_ready, stk_opcode}),
          int'({1'b1, 2'b11, 8'h00, 1'b0, 3'b000}));
    end
    release_res();

    // reset while draining at depth 100
    for (int i = 0; i < 100; i++) send(K_OP, 8'(i));
    send(K_END, 8'h00);
    chk("t6_drain_depth", int'(depth_o), 100);
    chk("t6_drain_pop", int'(stk_opcode), int'(C_POP));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", int'({stk_opcode, stk_data, tok_ready, res_valid, res_data, res_err, res_arith_ovf}), 0);
    chk("t6_rst_depth", int'(depth_o), 0);
    mstk.delete(); exp_ops.delete(); exp_res.delete();
    mskip = 1'b0; merr = 2'b00; movf = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1 chk("t6_init", int'(tok_ready), 0);
    @(negedge clk) chk("t6_accept", int'(tok_ready), 1);
    @(posedge clk); #1;
    send(K_OP, 8'h04); send(K_END, 8'h00);
    wait_res(k);
    chk("t6_data", int'(res_data), 8'h04);
    release_res();

    // random token streams, random result back-pressure
    rr_mode = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      t = int'($urandom_range(0, 99));
      kk = (t < 45) ? K_OP : (t < 60) ? K_ADD : (t < 75) ? K_MUL : K_END;
      send(kk, 8'($urandom));
    end
    send(K_END, 8'h00);
    rr_mode = 2;
    k = 0;
    while ((exp_res.size() != 0 || res_valid) && k < 2000) begin @(negedge clk); k++; end
    chk("results_outstanding", exp_res.size(), 0);
    chk("ops_outstanding", exp_ops.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
